// File: rtl/phv_egress_fifo_if.sv
// PHV egress FIFO handshake bundle.
// slave is the FIFO side, master is the upstream/deparser side.
interface phv_egress_fifo_if #(
    parameter int PHV_LEN = 1024,
    parameter int ADDR_W  = 4
);
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               phv_fifo_ready;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               phv_out_ready;
    logic [ADDR_W:0]    fifo_count;
    logic [31:0]        overflow_cnt;
    logic               overflow_pulse;

    modport slave (
        input  phv_in, phv_in_valid, phv_out_ready,
        output phv_fifo_ready, phv_out, phv_out_valid,
        output fifo_count, overflow_cnt, overflow_pulse
    );

    modport master (
        output phv_in, phv_in_valid, phv_out_ready,
        input  phv_fifo_ready, phv_out, phv_out_valid,
        input  fifo_count, overflow_cnt, overflow_pulse
    );
endinterface

// File: rtl/phv_egress_fifo.sv
// First-word-fall-through PHV buffer ahead of the deparser with
// early ready (AF_SLACK free entries) and saturating drop counter.
module phv_egress_fifo #(
    parameter int PHV_LEN  = 1024,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 4,
    parameter int AF_SLACK = 4
) (
    input  logic              axis_clk,
    input  logic              areset,
    phv_egress_fifo_if.slave  bus
);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_THR   = (ADDR_W+1)'(DEPTH - AF_SLACK);

    logic [PHV_LEN-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_rd_ptr;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic [ADDR_W:0]    r_count;
    logic               r_ready;
    logic [31:0]        r_ovf_cnt;
    logic               r_ovf_pulse;

    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic               w_drop;
    logic [ADDR_W:0]    w_count_next;

    assign w_pop  = (r_count != '0) & bus.phv_out_ready;
    assign w_full = (r_count == LP_DEPTH);
    assign w_push = bus.phv_in_valid & (~w_full | w_pop);
    assign w_drop = bus.phv_in_valid & w_full & ~w_pop;

    assign w_count_next = r_count
                        + {{ADDR_W{1'b0}}, w_push}
                        - {{ADDR_W{1'b0}}, w_pop};

    // Storage is not reset; validity is tracked by r_count alone.
    always_ff @(posedge axis_clk) begin
        if (!areset && w_push) begin
            r_mem[r_wr_ptr] <= bus.phv_in;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_ready     <= 1'b0;
            r_ovf_cnt   <= '0;
            r_ovf_pulse <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            r_count     <= w_count_next;
            r_ready     <= (w_count_next <= LP_THR);
            r_ovf_pulse <= w_drop;
            if (w_drop && (r_ovf_cnt != 32'hFFFF_FFFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 32'd1;
            end
        end
    end

    assign bus.phv_out        = r_mem[r_rd_ptr];
    assign bus.phv_out_valid  = (r_count != '0);
    assign bus.phv_fifo_ready = r_ready;
    assign bus.fifo_count     = r_count;
    assign bus.overflow_cnt   = r_ovf_cnt;
    assign bus.overflow_pulse = r_ovf_pulse;
endmodule

// File: tb/tb_phv_egress_fifo.sv
// Directed bench for phv_egress_fifo: reset, single beat, fill/drop,
// full push+pop, flow-controlled streaming and mid-run reset.
module tb_phv_egress_fifo;
    logic clk = 1'b0;
    logic areset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    phv_egress_fifo_if #(.PHV_LEN(1024), .ADDR_W(4)) bus ();

    phv_egress_fifo #(
        .PHV_LEN(1024), .DEPTH(16), .ADDR_W(4), .AF_SLACK(4)
    ) dut (
        .axis_clk(clk),
        .areset  (areset),
        .bus     (bus)
    );

    function automatic logic [1023:0] pat(input logic [7:0] t);
        return {16{56'h1234_5678_9ABC_DE, t}};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_phv(input string tag, input logic [1023:0] obs,
                           input logic [1023:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs_lo=%0h exp_lo=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    initial begin
        logic [7:0] pv [3];
        logic       pq [3];
        int         sent;
        int         rx;
        int         cyc;

        areset = 1'b1;
        bus.phv_in = pat(8'hEE);
        bus.phv_in_valid = 1'b1;
        bus.phv_out_ready = 1'b0;

        // reset held 3 cycles with input activity
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_count", 64'(bus.fifo_count), 64'd0);
            chk("rst_valid", 64'(bus.phv_out_valid), 64'd0);
            chk("rst_ready", 64'(bus.phv_fifo_ready), 64'd0);
        end
        chk("rst_ovf", 64'(bus.overflow_cnt), 64'd0);
        chk("rst_pulse", 64'(bus.overflow_pulse), 64'd0);
        areset = 1'b0;
        bus.phv_in_valid = 1'b0;
        @(negedge clk);
        chk("rel_ready", 64'(bus.phv_fifo_ready), 64'd1);
        chk("rel_count", 64'(bus.fifo_count), 64'd0);

        // single beat
        bus.phv_in = 1024'hA5;
        bus.phv_in_valid = 1'b1;
        bus.phv_out_ready = 1'b1;
        @(negedge clk);
        bus.phv_in_valid = 1'b0;
        chk("sb_valid", 64'(bus.phv_out_valid), 64'd1);
        chk_phv("sb_data", bus.phv_out, 1024'hA5);
        chk("sb_count1", 64'(bus.fifo_count), 64'd1);
        @(negedge clk);
        chk("sb_valid0", 64'(bus.phv_out_valid), 64'd0);
        chk("sb_count0", 64'(bus.fifo_count), 64'd0);

        // fill to full, then one drop
        bus.phv_out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus.phv_in = pat(8'(i));
            bus.phv_in_valid = 1'b1;
            @(negedge clk);
            if (i <= 16) begin
                chk("fill_count", 64'(bus.fifo_count), 64'(i));
                chk("fill_ready", 64'(bus.phv_fifo_ready), (i <= 12) ? 64'd1 : 64'd0);
                chk("fill_ovf", 64'(bus.overflow_cnt), 64'd0);
            end else begin
                chk("drop_count", 64'(bus.fifo_count), 64'd16);
                chk("drop_ovf", 64'(bus.overflow_cnt), 64'd1);
                chk("drop_pulse", 64'(bus.overflow_pulse), 64'd1);
                chk("drop_ready", 64'(bus.phv_fifo_ready), 64'd0);
            end
        end

        // full with simultaneous push and pop
        bus.phv_out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            bus.phv_in = pat(8'(100 + j));
            bus.phv_in_valid = 1'b1;
            chk_phv("fp_head", bus.phv_out, pat(8'(1 + j)));
            @(negedge clk);
            chk("fp_count", 64'(bus.fifo_count), 64'd16);
            chk("fp_ovf", 64'(bus.overflow_cnt), 64'd1);
            chk("fp_pulse", 64'(bus.overflow_pulse), 64'd0);
        end

        // drain and verify order
        bus.phv_in_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk("dr_valid", 64'(bus.phv_out_valid), 64'd1);
            chk_phv("dr_data", bus.phv_out,
                    pat((k < 11) ? 8'(6 + k) : 8'(100 + k - 11)));
            @(negedge clk);
        end
        chk("dr_count", 64'(bus.fifo_count), 64'd0);
        chk("dr_valid0", 64'(bus.phv_out_valid), 64'd0);

        // reset to clear the drop counter before streaming
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        chk("st_ovf0", 64'(bus.overflow_cnt), 64'd0);

        // streaming with 3-cycle upstream flight delay
        for (int i = 0; i < 3; i++) begin
            pq[i] = 1'b0;
            pv[i] = '0;
        end
        sent = 0;
        rx = 0;
        cyc = 0;
        while (rx < 200 && cyc < 3000) begin
            bus.phv_out_ready = (cyc % 3) != 2;
            if (bus.phv_out_valid && bus.phv_out_ready) begin
                chk_phv("st_data", bus.phv_out, pat(8'(rx)));
                rx++;
            end
            bus.phv_in_valid = pq[2];
            bus.phv_in = pat(pv[2]);
            pq[2] = pq[1];
            pv[2] = pv[1];
            pq[1] = pq[0];
            pv[1] = pv[0];
            pq[0] = bus.phv_fifo_ready && (sent < 200);
            pv[0] = 8'(sent);
            if (pq[0]) sent++;
            cyc++;
            @(negedge clk);
        end
        bus.phv_in_valid = 1'b0;
        bus.phv_out_ready = 1'b0;
        chk("st_rx", 64'(rx), 64'd200);
        chk("st_ovf", 64'(bus.overflow_cnt), 64'd0);
        chk("st_count", 64'(bus.fifo_count), 64'd0);

        // build count=7, overflow_cnt=2, then reset mid-operation
        for (int i = 0; i < 18; i++) begin
            bus.phv_in = pat(8'(i));
            bus.phv_in_valid = 1'b1;
            @(negedge clk);
        end
        bus.phv_in_valid = 1'b0;
        bus.phv_out_ready = 1'b1;
        repeat (9) @(negedge clk);
        bus.phv_out_ready = 1'b0;
        chk("mr_count7", 64'(bus.fifo_count), 64'd7);
        chk("mr_ovf2", 64'(bus.overflow_cnt), 64'd2);
        areset = 1'b1;
        bus.phv_in = pat(8'h77);
        bus.phv_in_valid = 1'b1;
        @(negedge clk);
        chk("mr_count0", 64'(bus.fifo_count), 64'd0);
        chk("mr_valid0", 64'(bus.phv_out_valid), 64'd0);
        chk("mr_ovf0", 64'(bus.overflow_cnt), 64'd0);
        areset = 1'b0;
        bus.phv_in = pat(8'h33);
        @(negedge clk);
        bus.phv_in_valid = 1'b0;
        chk("mr_valid1", 64'(bus.phv_out_valid), 64'd1);
        chk("mr_count1", 64'(bus.fifo_count), 64'd1);
        chk_phv("mr_first", bus.phv_out, pat(8'h33));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/phv_egress_fifo.md
Name: phv_egress_fifo

Overview:
- Buffers the final-stage PHV stream ahead of the deparser; sits directly downstream of the last pipeline stage.
- The last stage registers its PHV output without honouring backpressure on the in-flight beat. This block therefore drives an early ready (phv_fifo_ready) with configurable slack and absorbs in-flight beats.
- Presents a first-word-fall-through valid/ready interface to the deparser and counts any dropped PHVs.

Parameters:
- PHV_LEN, 1024, PHV width in bits (48*8+32*8+16*8+256).
- DEPTH, 16, number of PHV entries; power of two, >=4.
- ADDR_W, 4, log2(DEPTH).
- AF_SLACK, 4, free entries still required when ready is asserted; covers upstream flight latency; legal 1..DEPTH-1.

Ports:
- axis_clk  in  1  clock; all logic is on the rising edge.
- areset  in  1  synchronous reset, active-high.
- phv_in  in  PHV_LEN  PHV from the last stage.
- phv_in_valid  in  1  phv_in is valid this cycle; not gated by phv_fifo_ready.
- phv_fifo_ready  out  1  registered; upstream may issue new PHVs.
- phv_out  out  PHV_LEN  head-of-FIFO PHV to the deparser.
- phv_out_valid  out  1  FIFO non-empty.
- phv_out_ready  in  1  deparser accepts phv_out.
- fifo_count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow_cnt  out  32  saturating count of dropped PHVs.
- overflow_pulse  out  1  registered; high for one cycle after each drop.

Behaviour:
- Reset (areset=1 at a clock edge):
  - rd_ptr, wr_ptr and count go to 0.
  - phv_fifo_ready=0, phv_out_valid=0, overflow_cnt=0, overflow_pulse=0.
  - phv_out is don't-care while valid=0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all stored PHVs immediately; inputs are ignored while areset=1.
- pop = phv_out_valid & phv_out_ready.
- push_ok = phv_in_valid & ((count < DEPTH) | pop).
- drop = phv_in_valid & (count == DEPTH) & ~pop.
- Push: mem[wr_ptr] <= phv_in; wr_ptr increments, wrapping DEPTH-1 -> 0.
- Pop: rd_ptr increments with the same wrap.
- count_next = count + push_ok - pop. Simultaneous push and pop leaves count unchanged, including at full and at count 1.
- Pop when empty cannot occur, because valid=0.
- Push into an empty FIFO: phv_out_valid=1 and phv_out=pushed data in the cycle after the push edge (1-cycle latency). Data is never forwarded combinationally from phv_in.
- phv_out = mem[rd_ptr]; phv_out_valid = (count != 0). Both derive only from registers.
- phv_out must stay stable while phv_out_valid=1 and phv_out_ready=0.
- phv_fifo_ready <= (count_next <= DEPTH - AF_SLACK), registered every cycle. It takes value 1 on the first edge after reset is released while empty.
- On drop:
  - The PHV is discarded and pointers are unchanged.
  - overflow_cnt increments, saturating at 32'hFFFF_FFFF (no wrap).
  - overflow_pulse <= 1 on the next cycle; otherwise overflow_pulse <= 0.
- Ordering: strictly FIFO. No reordering, duplication or partial-width writes.
- fifo_count is the registered count.

Test Plan:
- Reset: areset=1 for 3 cycles with phv_in_valid=1 -> fifo_count=0, phv_out_valid=0, phv_fifo_ready=0 throughout; phv_fifo_ready=1 on the first cycle after release.
- Single beat: push phv_in=1024'hA5 at edge N with phv_out_ready=1 -> phv_out_valid=1 with phv_out=1024'hA5 at N+1; valid=0 at N+2; fifo_count 1 then 0.
- Fill with phv_out_ready=0 (DEPTH=16, AF_SLACK=4), phv_in_valid=1 continuously:
  - phv_fifo_ready stays 1 through push 12 and goes 0 after push 13 (count_next=13).
  - Pushes 14-16 are accepted (count=16).
  - Push 17 is dropped: overflow_cnt=1, overflow_pulse high for exactly one cycle, fifo_count stays 16.
- Full with simultaneous push and pop: at count=16, assert phv_in_valid=1 and phv_out_ready=1 for 5 cycles -> count stays 16, no drops, and the output sequence equals the insertion sequence.
- Streaming: 200 PHVs tagged 0..199 in the low 8 bits, phv_out_ready toggling 1,1,0, upstream respecting phv_fifo_ready with a 3-cycle flight delay -> all 200 received in order, overflow_cnt=0.
- Reset mid-operation at count=7 with overflow_cnt=2 -> next cycle fifo_count=0, phv_out_valid=0, overflow_cnt=0; a subsequent push of tag 8'h33 emerges first.
